// File: rtl/codes.sv
// Shared encodings for the CPU phase sequencer and its memory bus controller.
package codes;

  typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALT} state_t;

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} bus_state_t;

  // Avalon addresses here are always word aligned; byte lanes go on byteenable.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_bus_ctrl.sv
// Single-master Avalon bus controller serving instruction fetches and data
// loads/stores for a multi-phase CPU, one outstanding transfer at a time.
import codes::*;

module mem_bus_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_i,
  input  state_t            state_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [DATA_W-1:0] writedata_o,
  output logic [3:0]        byteenable_o,
  input  logic              waitrequest_i,
  input  logic [DATA_W-1:0] readdata_i
);

  bus_state_t        bus_q, bus_d;
  logic [DATA_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] writedata_q, writedata_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [3:0]        be_q, be_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              fetch_q, fetch_d;
  logic              need_access;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    bus_d       = bus_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    instr_d     = instr_q;
    rdata_d     = rdata_q;
    be_d        = be_q;
    read_d      = read_q;
    write_d     = write_q;
    fetch_d     = fetch_q;

    need_access = (state_i == FETCH) ||
                  ((state_i == EXEC1) && (mem_read_i || mem_write_i));
    stall_o     = need_access && (bus_q != DONE);

    case (bus_q)
      IDLE: begin
        if (need_access) begin
          bus_d   = REQ;
          fetch_d = (state_i == FETCH);
          if (state_i == FETCH) begin
            address_d   = word_align(pc_i);
            read_d      = 1'b1;
            write_d     = 1'b0;
            be_d        = 4'hF;
            writedata_d = '0;
          end else begin
            // A simultaneous load and store request is treated as a load.
            address_d   = word_align(mem_addr_i);
            read_d      = mem_read_i;
            write_d     = mem_write_i && !mem_read_i;
            be_d        = be_i;
            writedata_d = wdata_i;
          end
        end
      end
      REQ: begin
        if (!waitrequest_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          bus_d   = read_q ? DATA : DONE;
        end
      end
      DATA: begin
        if (fetch_q) instr_d = readdata_i;
        else         rdata_d = readdata_i;
        bus_d = DONE;
      end
      DONE:    bus_d = IDLE;
      default: bus_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset_i) begin
      bus_q       <= IDLE;
      address_q   <= '0;
      writedata_q <= '0;
      instr_q     <= '0;
      rdata_q     <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      fetch_q     <= 1'b0;
    end else begin
      bus_q       <= bus_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      instr_q     <= instr_d;
      rdata_q     <= rdata_d;
      be_q        <= be_d;
      read_q      <= read_d;
      write_q     <= write_d;
      fetch_q     <= fetch_d;
    end
  end

  assign instr_o      = instr_q;
  assign rdata_o      = rdata_q;
  assign address_o    = address_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign writedata_o  = writedata_q;
  assign byteenable_o = be_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed vectors, random transactions
// against a transaction-level model, and hand-written reset/halt sequences.
module tb_mem_bus_ctrl;
  import codes::*;

  typedef struct {
    state_t      st;
    logic [31:0] pc;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wd;
    logic [3:0]  be;
    int          waits;
    logic [31:0] rdat;
    logic [31:0] exp_addr;
    logic        exp_read;
    logic        exp_write;
    logic [3:0]  exp_be;
    int          exp_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_i;
  state_t      state_i;
  logic [31:0] pc_i, mem_addr_i, wdata_i, readdata_i;
  logic        mem_read_i, mem_write_i, waitrequest_i;
  logic [3:0]  be_i;
  logic        stall_o, read_o, write_o;
  logic [31:0] instr_o, rdata_o, address_o, writedata_o;
  logic [3:0]  byteenable_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_instr, m_rdata;

  mem_bus_ctrl #(.DATA_W(32)) dut (
    .clk(clk), .reset_i(reset_i), .state_i(state_i), .pc_i(pc_i),
    .mem_addr_i(mem_addr_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .wdata_i(wdata_i), .be_i(be_i), .stall_o(stall_o), .instr_o(instr_o),
    .rdata_o(rdata_o), .address_o(address_o), .read_o(read_o), .write_o(write_o),
    .writedata_o(writedata_o), .byteenable_o(byteenable_o),
    .waitrequest_i(waitrequest_i), .readdata_i(readdata_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    state_i     = HALT;
    mem_read_i  = 1'b0;
    mem_write_i = 1'b0;
    waitrequest_i = 1'b0;
    readdata_i  = $urandom;
  endtask

  // Transaction-level expectation: what the bus should do for one CPU phase.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit is_f   = (v.st == FETCH);
    bit access = is_f || ((v.st == EXEC1) && (v.rd || v.wr));
    r.exp_read  = access && (is_f || v.rd);
    r.exp_write = access && !is_f && v.wr && !v.rd;
    r.exp_addr  = (is_f ? v.pc : v.addr) & 32'hFFFF_FFFC;
    r.exp_be    = is_f ? 4'hF : v.be;
    r.exp_stall = !access ? 0 : ((r.exp_read ? 3 : 2) + v.waits);
    return r;
  endfunction

  // Plays the CPU (holds the phase until stall_o drops) and the slave
  // (inserts v.waits wait cycles, returns data one cycle after acceptance).
  task automatic run_txn(input vec_t v, input string tag);
    int stalls = 0, accepts = 0, waits_left = v.waits, cyc = 0;
    bit data_next = 0, done = 0, seen = 0;
    logic [31:0] a0 = '0, wd0 = '0;
    logic        r0 = 0, w0 = 0;
    logic [3:0]  b0 = '0;
    @(negedge clk);
    state_i = v.st; pc_i = v.pc; mem_addr_i = v.addr; mem_read_i = v.rd;
    mem_write_i = v.wr; wdata_i = v.wd; be_i = v.be;
    while (!done && cyc < 60) begin
      #1;
      readdata_i = data_next ? v.rdat : $urandom;
      data_next  = 0;
      if (stall_o) stalls++;
      else done = 1;
      check({tag, " rw_exclusive"}, {31'b0, read_o & write_o}, 32'h0);
      if (read_o || write_o) begin
        if (!seen) begin
          seen = 1; a0 = address_o; r0 = read_o; w0 = write_o;
          b0 = byteenable_o; wd0 = writedata_o;
        end else begin
          check({tag, " held_addr"}, address_o, a0);
          check({tag, " held_ctl"}, {26'b0, read_o, write_o, byteenable_o},
                {26'b0, r0, w0, b0});
        end
        if (waits_left > 0) begin
          waitrequest_i = 1'b1;
          waits_left--;
        end else begin
          waitrequest_i = 1'b0;
          accepts++;
          data_next = read_o;
        end
      end else begin
        waitrequest_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    #1;
    check({tag, " timeout"}, {31'b0, done}, 32'h1);
    check({tag, " stall_cycles"}, stalls, v.exp_stall);
    check({tag, " accepts"}, accepts, (v.exp_read || v.exp_write) ? 1 : 0);
    if (seen) begin
      check({tag, " address"}, a0, v.exp_addr);
      check({tag, " rd_wr"}, {30'b0, r0, w0}, {30'b0, v.exp_read, v.exp_write});
      check({tag, " byteenable"}, {28'b0, b0}, {28'b0, v.exp_be});
      if (v.exp_write) check({tag, " writedata"}, wd0, v.wd);
    end
    if (v.exp_read && v.st == FETCH) m_instr = v.rdat;
    if (v.exp_read && v.st == EXEC1) m_rdata = v.rdat;
    check({tag, " instr"}, instr_o, m_instr);
    check({tag, " rdata"}, rdata_o, m_rdata);
    check({tag, " bus_quiet"}, {30'b0, read_o, write_o}, 32'h0);
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{FETCH, 32'hBFC0_0000, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h2402_0005,
               32'hBFC0_0000, 1, 0, 4'hF, 3};
    tbl[1] = '{FETCH, 32'h0040_0006, 32'h0, 0, 0, 32'h0, 4'h0, 3, 32'h8FA4_0000,
               32'h0040_0004, 1, 0, 4'hF, 6};
    tbl[2] = '{EXEC1, 32'h0, 32'h0000_1003, 0, 1, 32'hDEAD_BEEF, 4'h8, 0, 32'h0,
               32'h0000_1000, 0, 1, 4'h8, 2};
    tbl[3] = '{EXEC1, 32'h0, 32'h0000_2000, 1, 1, 32'h5555_AAAA, 4'hF, 0, 32'h1234_5678,
               32'h0000_2000, 1, 0, 4'hF, 3};
    tbl[4] = '{EXEC1, 32'h0, 32'h0000_3006, 1, 0, 32'h0, 4'hC, 1, 32'hCAFE_F00D,
               32'h0000_3004, 1, 0, 4'hC, 4};
    tbl[5] = '{EXEC1, 32'h0, 32'h0000_4000, 0, 0, 32'h0, 4'hF, 0, 32'h0,
               32'h0, 0, 0, 4'h0, 0};
    tbl[6] = '{EXEC2, 32'h0, 32'h0000_5000, 1, 0, 32'h0, 4'hF, 0, 32'h0,
               32'h0, 0, 0, 4'h0, 0};
    tbl[7] = '{HALT, 32'h0000_0100, 32'h0, 0, 0, 32'h0, 4'h0, 0, 32'h0,
               32'h0, 0, 0, 4'h0, 0};
    tbl[8] = '{EXEC1, 32'h0, 32'h0000_0401, 0, 1, 32'h0BAD_F00D, 4'h3, 2, 32'h0,
               32'h0000_0400, 0, 1, 4'h3, 4};

    // Reset with the CPU already in FETCH.
    reset_i = 1'b1; idle_inputs(); state_i = FETCH; pc_i = '0; mem_addr_i = '0;
    wdata_i = '0; be_i = '0;
    m_instr = '0; m_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("reset stall", {31'b0, stall_o}, 32'h1);
    check("reset rd_wr", {30'b0, read_o, write_o}, 32'h0);
    check("reset address", address_o, 32'h0);
    check("reset writedata", writedata_o, 32'h0);
    check("reset be", {28'b0, byteenable_o}, 32'h0);
    check("reset instr", instr_o, 32'h0);
    check("reset rdata", rdata_o, 32'h0);
    state_i = HALT;

    foreach (tbl[i]) run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      vec_t v;
      int   pick = $urandom_range(0, 9);
      v.st    = (pick < 4) ? FETCH : (pick < 8) ? EXEC1 : (pick == 8) ? EXEC2 : HALT;
      v.pc    = $urandom; v.addr = $urandom;
      v.rd    = 1'($urandom); v.wr = 1'($urandom);
      v.wd    = $urandom; v.be = 4'($urandom);
      v.waits = $urandom_range(0, 3); v.rdat = $urandom;
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    // Reset while a fetch is stuck in REQ under waitrequest.
    @(negedge clk);
    state_i = FETCH; pc_i = 32'h0000_0100; waitrequest_i = 1'b1;
    @(negedge clk);
    #1;
    check("rstreq read_before", {31'b0, read_o}, 32'h1);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0; state_i = HALT; waitrequest_i = 1'b0;
    #1;
    check("rstreq rd_wr", {30'b0, read_o, write_o}, 32'h0);
    check("rstreq address", address_o, 32'h0);
    check("rstreq be", {28'b0, byteenable_o}, 32'h0);
    check("rstreq writedata", writedata_o, 32'h0);
    check("rstreq instr", instr_o, 32'h0);
    check("rstreq rdata", rdata_o, 32'h0);
    m_instr = '0; m_rdata = '0;
    @(negedge clk);
    #1;
    check("rstreq idle", {30'b0, read_o, write_o}, 32'h0);

    // HALT arrives while a load waits in REQ: the load must still finish.
    @(negedge clk);
    state_i = EXEC1; mem_addr_i = 32'h0000_0052; mem_read_i = 1'b1; be_i = 4'hF;
    waitrequest_i = 1'b1;
    @(negedge clk);
    #1;
    check("halt read_req", {31'b0, read_o}, 32'h1);
    check("halt address", address_o, 32'h0000_0050);
    state_i = HALT; mem_read_i = 1'b0;
    #1;
    check("halt stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk);
    waitrequest_i = 1'b0;
    @(negedge clk);
    readdata_i = 32'h0BAD_CAFE;
    @(negedge clk);
    #1;
    readdata_i = $urandom;
    check("halt rdata", rdata_o, 32'h0BAD_CAFE);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("halt quiet", {30'b0, read_o, write_o}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
